// File: rtl/seq_nonrestoring_divider.sv
// ============================================================================
//  Module      : seq_nonrestoring_divider
//  Description : Multi-cycle unsigned integer divider built on the
//                non-restoring algorithm. Each clock does one add or subtract,
//                and a final step corrects the remainder. The block has a
//                start/done handshake and flags divide by zero.
//                Optional macro NRD_SIGNED_EN selects two's-complement
//                operands. That mode adds a FIXUP state that applies signs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_nonrestoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int             CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

`ifdef NRD_SIGNED_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, CORRECT = 2'd2, FIXUP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, CORRECT = 2'd2} state_t;
`endif

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH:0]   a_reg;      // signed partial remainder
  logic [WIDTH-1:0] q_reg;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] y_reg;      // divisor (magnitude in signed mode)
  logic [CW-1:0]    count;
  logic             zero_div;   // operation in flight has Y == 0

  logic [WIDTH:0]   y_ext;
  logic [WIDTH:0]   a_shift;
  logic [WIDTH:0]   a_step;
  logic [WIDTH-1:0] rem_fix;
  logic             zero_hold;
  logic [WIDTH-1:0] x_load;
  logic [WIDTH-1:0] y_load;

`ifdef NRD_SIGNED_EN
  logic             x_neg;      // dividend sign, and so the remainder sign
  logic             q_neg;      // operand signs differ, so the quotient is negated
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] quo_signed;
  logic [WIDTH-1:0] rem_signed;
`endif

  assign ready = (state == IDLE);

  // Datapath helpers: operand preparation, one non-restoring step, remainder correction
  always_comb begin
    y_ext   = {1'b0, y_reg};
    a_shift = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    a_step  = a_reg[WIDTH] ? (a_shift + y_ext) : (a_shift - y_ext);
    rem_fix = a_reg[WIDTH] ? (a_reg[WIDTH-1:0] + y_reg) : a_reg[WIDTH-1:0];
    // Divide by zero spends two cycles in CORRECT so that its completion
    // latency is a fixed two clocks after accept.
    zero_hold = zero_div && (count == '0);
`ifdef NRD_SIGNED_EN
    x_load = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    y_load = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
`else
    x_load = dividend;
    y_load = divisor;
`endif
  end

`ifdef NRD_SIGNED_EN
  // Sign application for the FIXUP stage (MIN / -1 wraps naturally)
  always_comb begin
    rem_mag    = zero_div ? q_reg : a_reg[WIDTH-1:0];
    quo_signed = q_neg ? (~q_reg + 1'b1) : q_reg;
    rem_signed = x_neg ? (~rem_mag + 1'b1) : rem_mag;
  end
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (divisor == '0) ? CORRECT : ITER;
        end
      end
      ITER: begin
        if (count == LAST_STEP) begin
          state_nxt = CORRECT;
        end
      end
      CORRECT: begin
        if (!zero_hold) begin
`ifdef NRD_SIGNED_EN
          state_nxt = FIXUP;
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef NRD_SIGNED_EN
      FIXUP: begin
        state_nxt = IDLE;
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers, result registers and the one-cycle done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg       <= '0;
      q_reg       <= '0;
      y_reg       <= '0;
      count       <= '0;
      zero_div    <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef NRD_SIGNED_EN
      x_neg       <= 1'b0;
      q_neg       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            q_reg    <= x_load;
            a_reg    <= '0;
            y_reg    <= y_load;
            count    <= '0;
            zero_div <= (divisor == '0);
`ifdef NRD_SIGNED_EN
            x_neg    <= dividend[WIDTH-1];
            q_neg    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
`endif
          end
        end
        ITER: begin
          a_reg <= a_step;
          q_reg <= {q_reg[WIDTH-2:0], ~a_step[WIDTH]};
          count <= count + CNT_ONE;
        end
        CORRECT: begin
          if (zero_hold) begin
            count <= count + CNT_ONE;
          end else begin
`ifdef NRD_SIGNED_EN
            a_reg <= {1'b0, rem_fix};
`else
            done        <= 1'b1;
            div_by_zero <= zero_div;
            quotient    <= zero_div ? '1 : q_reg;
            remainder   <= zero_div ? q_reg : rem_fix;
`endif
          end
        end
`ifdef NRD_SIGNED_EN
        FIXUP: begin
          done        <= 1'b1;
          div_by_zero <= zero_div;
          quotient    <= zero_div ? '1 : quo_signed;
          remainder   <= rem_signed;
        end
`endif
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
